// File: rtl/mem_access_unit_if.sv
// Memory-side handshake bundle for the load/store unit: request fields out,
// ready and read data back in the same cycle.
interface mem_access_unit_if;
   logic        mem_valid;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
      input  mem_ready, mem_rdata
   );

   modport slave (
      input  mem_valid, mem_we, mem_addr, mem_be, mem_wdata,
      output mem_ready, mem_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store unit: latches one controller request, runs a valid/ready access
// to variable-latency memory with timeout, and returns formatted load data.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_req,
   input  logic [1:0]        memwrite,
   input  logic [1:0]        ltype,
   input  logic [31:0]       addr,
   input  logic [31:0]       wdata,
   mem_access_unit_if.master mem,
   output logic [31:0]       rdata,
   output logic              done,
   output logic              err,
   output logic              busy
);

   typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
   typedef enum logic [1:0] {SZ_WORD, SZ_HALF, SZ_BYTE} size_e;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   state_e      state_q, state_d;
   size_e       size_q, size_d, req_size;
   logic        we_q, we_d;
   logic        sext_q, sext_d;
   logic        err_q, err_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        accept, misalign;
   logic [31:0] lane_shift, load_val;
   logic [3:0]  be_full;
   logic [31:0] wdata_rep;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         size_q  <= SZ_WORD;
         we_q    <= 1'b0;
         sext_q  <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         size_q  <= size_d;
         we_q    <= we_d;
         sext_q  <= sext_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         cnt_q   <= cnt_d;
      end
   end

   // A store on memwrite takes priority over a simultaneous rd_req.
   always_comb begin
      state_d  = state_q;
      size_d   = size_q;
      we_d     = we_q;
      sext_d   = sext_q;
      err_d    = err_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      cnt_d    = cnt_q;
      accept   = rd_req | (memwrite != 2'b00);
      req_size = SZ_WORD;
      if (memwrite != 2'b00) begin
         case (memwrite)
            2'b01:   req_size = SZ_WORD;
            2'b10:   req_size = SZ_BYTE;
            default: req_size = SZ_HALF;
         endcase
      end else begin
         case (ltype)
            2'b00:   req_size = SZ_WORD;
            2'b11:   req_size = SZ_HALF;
            default: req_size = SZ_BYTE;
         endcase
      end
      misalign = ((req_size == SZ_WORD) && (addr[1:0] != 2'b00)) ||
                 ((req_size == SZ_HALF) && addr[0]);

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (accept) begin
               addr_d  = addr;
               wdata_d = wdata;
               we_d    = (memwrite != 2'b00);
               sext_d  = (ltype != 2'b10);
               size_d  = req_size;
               err_d   = misalign;
               state_d = misalign ? RESP : REQ;
            end
         end
         REQ: begin
            if (mem.mem_ready) begin
               state_d = RESP;
               if (!we_q) rdata_d = load_val;
            end else if (cnt_q == CNT_LAST) begin
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Shifting the addressed lane down to bit 0 covers all three load sizes.
   always_comb begin
      lane_shift = mem.mem_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         SZ_BYTE: load_val = {{24{sext_q & lane_shift[7]}}, lane_shift[7:0]};
         SZ_HALF: load_val = {{16{sext_q & lane_shift[15]}}, lane_shift[15:0]};
         default: load_val = lane_shift;
      endcase
   end

   always_comb begin
      case (size_q)
         SZ_BYTE: begin
            be_full   = 4'b0001 << addr_q[1:0];
            wdata_rep = {4{wdata_q[7:0]}};
         end
         SZ_HALF: begin
            be_full   = addr_q[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata_q[15:0]}};
         end
         default: begin
            be_full   = 4'b1111;
            wdata_rep = wdata_q;
         end
      endcase
      mem.mem_valid = (state_q == REQ);
      mem.mem_we    = (state_q == REQ) & we_q;
      mem.mem_addr  = (state_q == REQ) ? {addr_q[31:2], 2'b00} : '0;
      mem.mem_be    = (state_q == REQ) ? be_full : '0;
      mem.mem_wdata = (state_q == REQ) ? wdata_rep : '0;
      done          = (state_q == RESP);
      err           = (state_q == RESP) & err_q;
      busy          = (state_q != IDLE);
      rdata         = rdata_q;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboarded bench for mem_access_unit: a byte-level memory model predicts
// every bus transaction and every done/err/rdata completion.
module tb_mem_access_unit;
   localparam int unsigned TB_TO = 8;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int unsigned done_cyc;
   } sb_t;

   typedef struct {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      int unsigned lat;
   } bus_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd_req;
   logic [1:0]  memwrite, ltype;
   logic [31:0] addr, wdata, rdata;
   logic        done, err, busy;

   logic        t4_rd_req;
   logic [1:0]  t4_memwrite, t4_ltype;
   logic [31:0] t4_addr, t4_wdata, t4_rdata;
   logic        t4_done, t4_err, t4_busy;

   mem_access_unit_if bus ();
   mem_access_unit_if if4 ();

   mem_access_unit #(.TIMEOUT(TB_TO)) dut (
      .clk(clk), .reset(reset), .rd_req(rd_req), .memwrite(memwrite),
      .ltype(ltype), .addr(addr), .wdata(wdata), .mem(bus),
      .rdata(rdata), .done(done), .err(err), .busy(busy)
   );

   mem_access_unit #(.TIMEOUT(4)) dut4 (
      .clk(clk), .reset(reset), .rd_req(t4_rd_req), .memwrite(t4_memwrite),
      .ltype(t4_ltype), .addr(t4_addr), .wdata(t4_wdata), .mem(if4),
      .rdata(t4_rdata), .done(t4_done), .err(t4_err), .busy(t4_busy)
   );

   assign if4.mem_ready = 1'b0;
   assign if4.mem_rdata = '0;

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   sb_t  sbq[$];
   bus_t busq[$];
   logic [31:0] memarr [256];
   logic [31:0] refmem [256];
   logic [31:0] last_rdata = '0;
   int unsigned kcnt = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: access size from type, lanes from byte offset, extension by sign bit.
   task automatic model_push(input logic [1:0] mw, input logic [1:0] lt, input logic [31:0] a,
                             input logic [31:0] wd, input int unsigned lat);
      int unsigned size, off, idx;
      bit store, sgn;
      sb_t s;
      bus_t b;
      logic [31:0] w, v;
      store = (mw != 2'b00);
      if (store) size = (mw == 2'b01) ? 4 : (mw == 2'b10) ? 1 : 2;
      else       size = (lt == 2'b00) ? 4 : (lt == 2'b11) ? 2 : 1;
      sgn = (lt != 2'b10);
      off = a % 4;
      idx = (a / 4) % 256;
      if ((a % size) != 0) begin
         s.rdata = last_rdata; s.err = 1'b1; s.done_cyc = cyc + 1;
         sbq.push_back(s);
         return;
      end
      b.addr = a - off; b.we = store; b.lat = lat; b.be = '0; b.wdata = '0;
      for (int i = 0; i < 4; i++) b.wdata[8*i +: 8] = wd[8*(i % size) +: 8];
      for (int i = 0; i < size; i++) b.be[off + i] = 1'b1;
      busq.push_back(b);
      if (lat >= TB_TO) begin
         s.rdata = last_rdata; s.err = 1'b1; s.done_cyc = cyc + 1 + TB_TO;
      end else begin
         if (store) begin
            for (int i = 0; i < 4; i++)
               if (b.be[i]) refmem[idx][8*i +: 8] = b.wdata[8*i +: 8];
         end else begin
            w = refmem[idx];
            v = '0;
            for (int i = 0; i < size; i++) v[8*i +: 8] = w[8*(off + i) +: 8];
            if (sgn && size < 4 && v[8*size - 1])
               for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
            last_rdata = v;
         end
         s.rdata = last_rdata; s.err = 1'b0; s.done_cyc = cyc + 2 + lat;
      end
      sbq.push_back(s);
   endtask

   // Memory responder: checks each valid cycle against the predicted access.
   always @(negedge clk) begin
      if (reset) begin
         kcnt = 0;
         bus.mem_ready = 1'b0;
      end else if (bus.mem_valid) begin
         bus.mem_rdata = memarr[bus.mem_addr[9:2]];
         if (busq.size() == 0) begin
            chk("bus_unexpected_valid", {bus.mem_addr, bus.mem_be}, '0);
            bus.mem_ready = 1'b0;
         end else begin
            chk("bus_addr_we_be", {bus.mem_addr, bus.mem_we, bus.mem_be},
                {busq[0].addr, busq[0].we, busq[0].be});
            if (busq[0].we) chk("bus_wdata", bus.mem_wdata, busq[0].wdata);
            if (kcnt == busq[0].lat) begin
               bus.mem_ready = 1'b1;
               if (bus.mem_we)
                  for (int i = 0; i < 4; i++)
                     if (bus.mem_be[i]) memarr[bus.mem_addr[9:2]][8*i +: 8] = bus.mem_wdata[8*i +: 8];
               void'(busq.pop_front());
               kcnt = 0;
            end else if (kcnt == TB_TO - 1) begin
               bus.mem_ready = 1'b0;
               void'(busq.pop_front());
               kcnt = 0;
            end else begin
               bus.mem_ready = 1'b0;
               kcnt++;
            end
         end
      end else begin
         bus.mem_ready = 1'b0;
         kcnt = 0;
      end
   end

   // Completion monitor.
   always @(negedge clk) begin
      sb_t e;
      if (!reset && done) begin
         if (sbq.size() == 0) begin
            chk("done_unexpected", {rdata, err}, '0);
         end else begin
            e = sbq.pop_front();
            chk("rdata", rdata, e.rdata);
            chk("err", err, e.err);
            chk("done_cycle", cyc, e.done_cyc);
         end
      end else if (!reset && err) begin
         chk("err_without_done", err, 1'b0);
      end
   end

   task automatic issue(input logic rr, input logic [1:0] mw, input logic [1:0] lt,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int unsigned lat, input bit poke);
      int unsigned n;
      @(negedge clk);
      rd_req = rr; memwrite = mw; ltype = lt; addr = a; wdata = wd;
      model_push(mw, lt, a, wd, lat);
      @(negedge clk);
      rd_req = 1'b0; memwrite = 2'b00;
      n = 0;
      while (!done && n < 60) begin
         if (poke && n == 0) begin
            chk("busy_in_req", busy, 1'b1);
            rd_req = 1'b1;
         end
         if (poke && n == 2) rd_req = 1'b0;
         @(negedge clk);
         n++;
      end
      rd_req = 1'b0;
      if (!done) chk("done_wait_timeout", done, 1'b1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned vcount, dcount, dcyc, c0, lat, r;
      logic errd;
      logic [1:0] mw, lt;
      logic [31:0] a;

      reset = 1'b1; rd_req = 1'b0; memwrite = '0; ltype = '0; addr = '0; wdata = '0;
      t4_rd_req = 1'b0; t4_memwrite = '0; t4_ltype = '0; t4_addr = '0; t4_wdata = '0;
      bus.mem_ready = 1'b0; bus.mem_rdata = '0;
      for (int i = 0; i < 256; i++) begin
         memarr[i] = $urandom;
         refmem[i] = memarr[i];
      end
      memarr[8'h40] = 32'hDEADBEEF; refmem[8'h40] = 32'hDEADBEEF;
      memarr[8'h80] = 32'h80FF7F01; refmem[8'h80] = 32'h80FF7F01;
      memarr[8'hC0] = 32'h80FF7F01; refmem[8'hC0] = 32'h80FF7F01;

      repeat (2) @(negedge clk);
      chk("reset_outputs", {bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata,
                            rdata, done, err, busy}, '0);
      reset = 1'b0;

      issue(1'b1, 2'b00, 2'b00, 32'h100, 32'h0, 0, 1'b0);
      issue(1'b1, 2'b00, 2'b01, 32'h203, 32'h0, 0, 1'b0);
      issue(1'b1, 2'b00, 2'b10, 32'h203, 32'h0, 1, 1'b0);
      issue(1'b1, 2'b00, 2'b11, 32'h302, 32'h0, 0, 1'b0);
      issue(1'b0, 2'b10, 2'b00, 32'h301, 32'h000000AB, 0, 1'b0);
      issue(1'b1, 2'b00, 2'b00, 32'h300, 32'h0, 2, 1'b0);
      issue(1'b0, 2'b11, 2'b00, 32'h30E, 32'h1234C0DE, 3, 1'b0);
      issue(1'b1, 2'b00, 2'b00, 32'h100, 32'h0, 5, 1'b1);
      issue(1'b1, 2'b00, 2'b00, 32'h102, 32'h0, 0, 1'b0);
      issue(1'b1, 2'b00, 2'b11, 32'h105, 32'h0, 0, 1'b0);
      issue(1'b1, 2'b00, 2'b01, 32'h100, 32'h0, 20, 1'b0);
      issue(1'b1, 2'b00, 2'b00, 32'h100, 32'h0, TB_TO - 1, 1'b0);
      issue(1'b1, 2'b01, 2'b00, 32'h10, 32'h12345678, 1, 1'b0);
      issue(1'b1, 2'b00, 2'b00, 32'h10, 32'h0, 0, 1'b0);

      @(negedge clk);
      t4_rd_req = 1'b1; t4_addr = 32'h40; t4_ltype = 2'b00;
      c0 = cyc; vcount = 0; dcount = 0; dcyc = 0; errd = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (i == 0) t4_rd_req = 1'b0;
         if (if4.mem_valid) vcount++;
         if (t4_done) begin dcount++; dcyc = cyc; errd = t4_err; end
      end
      chk("t4_valid_cycles", vcount, 4);
      chk("t4_done_count", dcount, 1);
      chk("t4_done_cycle", dcyc, c0 + 5);
      chk("t4_err", errd, 1'b1);
      chk("t4_rdata_kept", t4_rdata, '0);

      @(negedge clk);
      rd_req = 1'b1; ltype = 2'b00; addr = 32'h20;
      model_push(2'b00, 2'b00, 32'h20, 32'h0, 30);
      @(negedge clk);
      rd_req = 1'b0;
      @(negedge clk);
      chk("valid_before_reset", bus.mem_valid, 1'b1);
      #2 reset = 1'b1;
      #1 chk("outputs_after_reset", {bus.mem_valid, bus.mem_we, bus.mem_addr, bus.mem_be,
                                     bus.mem_wdata, rdata, done, err, busy}, '0);
      sbq.delete();
      busq.delete();
      last_rdata = '0;
      @(negedge clk);
      #2 reset = 1'b0;
      repeat (3) @(negedge clk);

      for (int t = 0; t < 200; t++) begin
         mw = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
         lt = 2'($urandom_range(0, 3));
         a = 32'($urandom_range(0, 1023));
         r = $urandom_range(0, 9);
         if (r < 6) a[1:0] = 2'b00;
         else if (r < 8) a[0] = 1'b0;
         lat = $urandom_range(0, TB_TO);
         issue((mw == 2'b00) ? 1'b1 : 1'($urandom_range(0, 1)), mw, lt, a, $urandom, lat, 1'b0);
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", sbq.size(), 0);
      chk("bus_queue_drained", busq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
